rgb_led_arbiter: RTL and testbench

Shares the single on-board RGB LED (rgb_led0) between several status sources in the CPU top level. Each requester asks for the LED with a 24-bit colour; a priority arbiter grants one requester at a time with a minimum hold time. An 8-bit PWM engine, clocked from clk48 through a prescaler, renders the granted colour onto the active-low LED pins.

---
 rtl/rgb_led_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_rgb_led_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: shares the single RGB LED (rgb_led0) between NREQ status
// sources. A two-state arbiter grants one requester with a minimum hold time.
// An 8-bit PWM engine, stepped by a clk48 prescaler, renders the granted
// colour onto the active-low LED pins.
// Optional feature: define RGB_LED_ARB_RR_EN for round-robin winner
// selection. When it is undefined, the lowest requesting index wins.
module rgb_led_arbiter #(
    parameter int NREQ         = 4,
    parameter int PWM_DIV      = 188,
    parameter int HOLD_PERIODS = 16
) (
    input  logic                 clk48,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [24*NREQ-1:0]   color,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 rgb_led0_r,
    output logic                 rgb_led0_g,
    output logic                 rgb_led0_b
);

    localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_PERIODS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PWM_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_PERIODS);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_next;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [7:0]        pwm_cnt_q, pwm_cnt_d;
    logic [23:0]       shadow_q, shadow_d;
    logic [2:0]        pins_q, pins_d;
    logic              tick, frame_end;
    logic [NREQ-1:0]   win_idle, win_pre;
    logic              others;

    // Frame counter saturates so a long-held grant never wraps back to "fresh".
    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
        if (v == HOLD_MAX) begin
            return v;
        end
        return v + HOLD_W'(1);
    endfunction

`ifdef RGB_LED_ARB_RR_EN
    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] last_q, last_d;

    // One-hot pick searching upward from last+1, wrapping modulo NREQ.
    function automatic logic [NREQ-1:0] pick_rr(input logic [NREQ-1:0] elig,
                                                 input logic [IDX_W-1:0] last);
        logic [NREQ-1:0]  oh;
        logic [IDX_W-1:0] sel;
        oh = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sel = IDX_W'((int'(last) + k) % NREQ);
            if (elig[sel] && (oh == '0)) begin
                oh[sel] = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NREQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Round-robin winners for a fresh grant and for a preemption.
    always_comb begin
        win_idle = pick_rr(req, last_q);
        win_pre  = pick_rr(req & ~grant_q, last_q);
    end
`else
    // One-hot pick of the lowest set index.
    function automatic logic [NREQ-1:0] pick_fixed(input logic [NREQ-1:0] elig);
        logic [NREQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (elig[i] && (oh == '0)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Fixed-priority winners for a fresh grant and for a preemption.
    always_comb begin
        win_idle = pick_fixed(req);
        win_pre  = pick_fixed(req & ~grant_q);
    end
`endif

    // Prescaler and PWM step counter; frame_end marks the last step of a frame.
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        frame_end = tick && (pwm_cnt_q == 8'hFF);
    end

    // Shadow colour only changes on a frame boundary so the PWM never glitches.
    always_comb begin
        shadow_d = shadow_q;
        if (frame_end) begin
            shadow_d = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (grant_q[i]) begin
                    shadow_d = color[24*i +: 24];
                end
            end
        end
    end

    // Active-low pins: lit while the step counter is below the channel duty.
    always_comb begin
        pins_d[2] = ~(pwm_cnt_q < shadow_q[23:16]);
        pins_d[1] = ~(pwm_cnt_q < shadow_q[15:8]);
        pins_d[0] = ~(pwm_cnt_q < shadow_q[7:0]);
    end

    // Arbiter FSM: grant, release on drop, preempt once the hold has elapsed.
    // hold_next counts the frame_end being processed now, so a grant with
    // HOLD_PERIODS=N can be preempted at its N-th frame_end.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        hold_next = hold_sat_inc(hold_q);
        others    = |(req & ~grant_q);
`ifdef RGB_LED_ARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    grant_d = win_idle;
                    hold_d  = '0;
`ifdef RGB_LED_ARB_RR_EN
                    last_d  = oh_to_idx(win_idle);
`endif
                end
            end
            ST_GRANT: begin
                // A dropped request always wins over a coincident preemption.
                if ((req & grant_q) == '0) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                end else if (frame_end) begin
                    if ((hold_next == HOLD_MAX) && others) begin
                        grant_d = win_pre;
                        hold_d  = '0;
`ifdef RGB_LED_ARB_RR_EN
                        last_d  = oh_to_idx(win_pre);
`endif
                    end else begin
                        hold_d = hold_next;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // All state registers; synchronous active-low reset turns the LED off.
    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            pwm_cnt_q <= '0;
            shadow_q  <= '0;
            pins_q    <= 3'b111;
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            hold_q    <= '0;
`ifdef RGB_LED_ARB_RR_EN
            last_q    <= IDX_W'(NREQ - 1);
`endif
        end else begin
            div_cnt_q <= div_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            shadow_q  <= shadow_d;
            pins_q    <= pins_d;
            state_q   <= state_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
`ifdef RGB_LED_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign busy       = |grant_q;
    assign rgb_led0_r = pins_q[2];
    assign rgb_led0_g = pins_q[1];
    assign rgb_led0_b = pins_q[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Bench for rgb_led_arbiter with PWM_DIV=1 (one PWM step per clock, 256-cycle
// frames). Edges are numbered from the last reset edge (edge 0), so the PWM
// step after edge k is k mod 256 and frame_end takes effect at edges 256, 512...
module tb_rgb_led_arbiter;

    localparam int NREQ    = 4;
    localparam int PWM_DIV = 1;
`ifdef RGB_LED_ARB_RR_EN
    localparam int HOLD    = 1;
`else
    localparam int HOLD    = 2;
`endif
    localparam int LIMIT   = 3000;
    localparam logic [23:0] C0 = 24'h40FF00;
    localparam logic [23:0] C1 = 24'h102030;
    localparam logic [23:0] C2 = 24'h000080;
    localparam logic [23:0] C3 = 24'h800000;

    logic                clk48;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [24*NREQ-1:0]  color;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic                rgb_led0_r, rgb_led0_g, rgb_led0_b;

    typedef struct {
        string          name;
        int             edge_n;
        logic [3:0]     grant;
        bit             chk_pins;
        logic [2:0]     pins;
    } exp_t;

    exp_t exp_q[$];
    int   cnt_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ecnt  = 0;

    rgb_led_arbiter #(
        .NREQ(NREQ),
        .PWM_DIV(PWM_DIV),
        .HOLD_PERIODS(HOLD)
    ) dut (
        .clk48(clk48),
        .rst_n(rst_n),
        .req(req),
        .color(color),
        .grant(grant),
        .busy(busy),
        .rgb_led0_r(rgb_led0_r),
        .rgb_led0_g(rgb_led0_g),
        .rgb_led0_b(rgb_led0_b)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    task automatic step();
        @(posedge clk48);
        #1;
        if (!rst_n) ecnt = 0;
        else        ecnt++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic push_exp(input string name, input int edge_n, input logic [3:0] g,
                            input bit chk, input logic [2:0] pins);
        exp_t e;
        e.name = name; e.edge_n = edge_n; e.grant = g; e.chk_pins = chk; e.pins = pins;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        req   = 4'b1111;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) push_exp("reset_hold", 0, 4'b0000, 1'b1, 3'b111);
        for (int i = 0; i < 5; i++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== e.grant || busy !== (|e.grant)) begin
                n_bad++;
                $display("FAIL %s cyc%0d grant/busy: got %b/%b want %b/%b", e.name, i, grant, busy, e.grant, |e.grant);
            end
            n_cmp++;
            if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== e.pins) begin
                n_bad++;
                $display("FAIL %s cyc%0d pins: got %b want %b", e.name, i, {rgb_led0_r, rgb_led0_g, rgb_led0_b}, e.pins);
            end
        end
        rst_n = 1'b1;
        push_exp("reset_release", 1, 4'b0001, 1'b1, 3'b111);
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (ecnt != e.edge_n || grant !== e.grant || busy !== (|e.grant)) begin
            n_bad++;
            $display("FAIL %s e%0d grant/busy: got %b/%b want %b/%b", e.name, ecnt, grant, busy, e.grant, |e.grant);
        end
        n_cmp++;
        if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== e.pins) begin
            n_bad++;
            $display("FAIL %s pins: got %b want %b", e.name, {rgb_led0_r, rgb_led0_g, rgb_led0_b}, e.pins);
        end
    endtask

    task automatic test_pwm_duty();
        exp_t e;
        int guard, nr, ng, nb, want;
        req = 4'b0001;
        apply_reset();
        push_exp("duty_grant",   1,   4'b0001, 1'b1, 3'b111);
        push_exp("duty_dark",    256, 4'b0001, 1'b1, 3'b111);
        push_exp("duty_first",   257, 4'b0001, 1'b1, 3'b001);
        cnt_q.push_back(64);
        cnt_q.push_back(255);
        cnt_q.push_back(0);
        guard = 0;
        while (exp_q.size() != 0 && guard < LIMIT) begin
            step();
            guard++;
            while (exp_q.size() != 0 && exp_q[0].edge_n == ecnt) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (grant !== e.grant || busy !== (|e.grant)) begin
                    n_bad++;
                    $display("FAIL %s e%0d grant/busy: got %b/%b want %b/%b", e.name, ecnt, grant, busy, e.grant, |e.grant);
                end
                if (e.chk_pins) begin
                    n_cmp++;
                    if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== e.pins) begin
                        n_bad++;
                        $display("FAIL %s e%0d pins: got %b want %b", e.name, ecnt, {rgb_led0_r, rgb_led0_g, rgb_led0_b}, e.pins);
                    end
                end
            end
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL duty_timeout: %0d expectations left, want 0", exp_q.size());
            exp_q.delete();
        end
        nr = 0; ng = 0; nb = 0;
        for (int s = 0; s < 256; s++) begin
            if (s != 0) step();
            if (rgb_led0_r === 1'b0) nr++;
            if (rgb_led0_g === 1'b0) ng++;
            if (rgb_led0_b === 1'b0) nb++;
        end
        want = cnt_q.pop_front();
        n_cmp++;
        if (nr != want) begin
            n_bad++;
            $display("FAIL duty_r low cycles: got %0d want %0d", nr, want);
        end
        want = cnt_q.pop_front();
        n_cmp++;
        if (ng != want) begin
            n_bad++;
            $display("FAIL duty_g low cycles: got %0d want %0d", ng, want);
        end
        want = cnt_q.pop_front();
        n_cmp++;
        if (nb != want) begin
            n_bad++;
            $display("FAIL duty_b low cycles: got %0d want %0d", nb, want);
        end
    endtask

`ifndef RGB_LED_ARB_RR_EN
    task automatic test_preempt();
        exp_t e;
        int guard;
        req = 4'b0001;
        apply_reset();
        push_exp("pre_first",    1,    4'b0001, 1'b0, 3'b111);
        push_exp("pre_before",   511,  4'b0001, 1'b0, 3'b111);
        push_exp("pre_switch",   512,  4'b0100, 1'b1, 3'b111);
        push_exp("pre_oldcolor", 513,  4'b0100, 1'b1, 3'b001);
        push_exp("pre_hold",     768,  4'b0100, 1'b0, 3'b111);
        push_exp("pre_newcolor", 769,  4'b0100, 1'b1, 3'b110);
        push_exp("pre_noregnt",  1023, 4'b0100, 1'b0, 3'b111);
        push_exp("pre_back",     1024, 4'b0001, 1'b0, 3'b111);
        guard = 0;
        while (exp_q.size() != 0 && guard < LIMIT) begin
            step();
            guard++;
            while (exp_q.size() != 0 && exp_q[0].edge_n == ecnt) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (grant !== e.grant || busy !== (|e.grant)) begin
                    n_bad++;
                    $display("FAIL %s e%0d grant/busy: got %b/%b want %b/%b", e.name, ecnt, grant, busy, e.grant, |e.grant);
                end
                if (e.chk_pins) begin
                    n_cmp++;
                    if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== e.pins) begin
                        n_bad++;
                        $display("FAIL %s e%0d pins: got %b want %b", e.name, ecnt, {rgb_led0_r, rgb_led0_g, rgb_led0_b}, e.pins);
                    end
                end
            end
            if (ecnt == 10) req = 4'b0101;
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pre_timeout: %0d expectations left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_drop_wins();
        exp_t e;
        int guard;
        req = 4'b0001;
        apply_reset();
        push_exp("dropw_before", 511, 4'b0001, 1'b0, 3'b111);
        push_exp("dropw_idle",   512, 4'b0000, 1'b0, 3'b111);
        push_exp("dropw_regnt",  513, 4'b0100, 1'b0, 3'b111);
        guard = 0;
        while (exp_q.size() != 0 && guard < LIMIT) begin
            step();
            guard++;
            while (exp_q.size() != 0 && exp_q[0].edge_n == ecnt) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (grant !== e.grant || busy !== (|e.grant)) begin
                    n_bad++;
                    $display("FAIL %s e%0d grant/busy: got %b/%b want %b/%b", e.name, ecnt, grant, busy, e.grant, |e.grant);
                end
            end
            if (ecnt == 10)  req = 4'b0101;
            if (ecnt == 511) req = 4'b0100;
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL dropw_timeout: %0d expectations left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask
`else
    task automatic test_round_robin();
        exp_t e;
        int guard;
        req = 4'b1111;
        apply_reset();
        push_exp("rr_first",  1,    4'b0001, 1'b0, 3'b111);
        push_exp("rr_keep0",  255,  4'b0001, 1'b0, 3'b111);
        push_exp("rr_to1",    256,  4'b0010, 1'b0, 3'b111);
        push_exp("rr_keep1",  511,  4'b0010, 1'b0, 3'b111);
        push_exp("rr_to2",    512,  4'b0100, 1'b0, 3'b111);
        push_exp("rr_to3",    768,  4'b1000, 1'b0, 3'b111);
        push_exp("rr_wrap",   1024, 4'b0001, 1'b0, 3'b111);
        guard = 0;
        while (exp_q.size() != 0 && guard < LIMIT) begin
            step();
            guard++;
            while (exp_q.size() != 0 && exp_q[0].edge_n == ecnt) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (grant !== e.grant || busy !== (|e.grant)) begin
                    n_bad++;
                    $display("FAIL %s e%0d grant/busy: got %b/%b want %b/%b", e.name, ecnt, grant, busy, e.grant, |e.grant);
                end
            end
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rr_timeout: %0d expectations left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask
`endif

    task automatic test_release();
        exp_t e;
        int guard;
        req = 4'b0010;
        apply_reset();
        push_exp("rel_grant1",  1,   4'b0010, 1'b0, 3'b111);
        push_exp("rel_held",    100, 4'b0010, 1'b0, 3'b111);
        push_exp("rel_gap",     101, 4'b0000, 1'b0, 3'b111);
        push_exp("rel_grant3",  102, 4'b1000, 1'b0, 3'b111);
        push_exp("rel_dark",    256, 4'b1000, 1'b1, 3'b111);
        push_exp("rel_color3",  257, 4'b1000, 1'b1, 3'b011);
        guard = 0;
        while (exp_q.size() != 0 && guard < LIMIT) begin
            step();
            guard++;
            while (exp_q.size() != 0 && exp_q[0].edge_n == ecnt) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (grant !== e.grant || busy !== (|e.grant)) begin
                    n_bad++;
                    $display("FAIL %s e%0d grant/busy: got %b/%b want %b/%b", e.name, ecnt, grant, busy, e.grant, |e.grant);
                end
                if (e.chk_pins) begin
                    n_cmp++;
                    if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== e.pins) begin
                        n_bad++;
                        $display("FAIL %s e%0d pins: got %b want %b", e.name, ecnt, {rgb_led0_r, rgb_led0_g, rgb_led0_b}, e.pins);
                    end
                end
            end
            if (ecnt == 2)   req = 4'b1010;
            if (ecnt == 100) req = 4'b1000;
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rel_timeout: %0d expectations left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_pulse();
        exp_t e;
        int guard;
        req = 4'b0000;
        apply_reset();
        push_exp("pulse_idle",  5, 4'b0000, 1'b0, 3'b111);
        push_exp("pulse_grant", 6, 4'b0010, 1'b0, 3'b111);
        push_exp("pulse_rel",   7, 4'b0000, 1'b0, 3'b111);
        push_exp("pulse_stay",  8, 4'b0000, 1'b1, 3'b111);
        guard = 0;
        while (exp_q.size() != 0 && guard < LIMIT) begin
            step();
            guard++;
            while (exp_q.size() != 0 && exp_q[0].edge_n == ecnt) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (grant !== e.grant || busy !== (|e.grant)) begin
                    n_bad++;
                    $display("FAIL %s e%0d grant/busy: got %b/%b want %b/%b", e.name, ecnt, grant, busy, e.grant, |e.grant);
                end
                if (e.chk_pins) begin
                    n_cmp++;
                    if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== e.pins) begin
                        n_bad++;
                        $display("FAIL %s e%0d pins: got %b want %b", e.name, ecnt, {rgb_led0_r, rgb_led0_g, rgb_led0_b}, e.pins);
                    end
                end
            end
            if (ecnt == 5) req = 4'b0010;
            if (ecnt == 6) req = 4'b0000;
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pulse_timeout: %0d expectations left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_midframe_reset();
        exp_t e;
        int guard;
        req = 4'b0001;
        apply_reset();
        push_exp("mid_lit",  257, 4'b0001, 1'b1, 3'b001);
        push_exp("mid_pre",  270, 4'b0001, 1'b1, 3'b001);
        for (int phase = 0; phase < 2; phase++) begin
            guard = 0;
            while (exp_q.size() != 0 && guard < LIMIT) begin
                step();
                guard++;
                while (exp_q.size() != 0 && exp_q[0].edge_n == ecnt) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (grant !== e.grant || busy !== (|e.grant)) begin
                        n_bad++;
                        $display("FAIL %s e%0d grant/busy: got %b/%b want %b/%b", e.name, ecnt, grant, busy, e.grant, |e.grant);
                    end
                    if (e.chk_pins) begin
                        n_cmp++;
                        if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== e.pins) begin
                            n_bad++;
                            $display("FAIL %s e%0d pins: got %b want %b", e.name, ecnt, {rgb_led0_r, rgb_led0_g, rgb_led0_b}, e.pins);
                        end
                    end
                end
            end
            if (exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL mid_timeout: %0d expectations left, want 0", exp_q.size());
                exp_q.delete();
            end
            if (phase == 0) begin
                // One-cycle reset pulse while the red and green channels are lit.
                rst_n = 1'b0;
                push_exp("mid_rst", 0, 4'b0000, 1'b1, 3'b111);
                step();
                e = exp_q.pop_front();
                n_cmp++;
                if (grant !== e.grant || busy !== (|e.grant) ||
                    {rgb_led0_r, rgb_led0_g, rgb_led0_b} !== e.pins) begin
                    n_bad++;
                    $display("FAIL %s grant/busy/pins: got %b/%b/%b want %b/%b/%b", e.name, grant, busy,
                             {rgb_led0_r, rgb_led0_g, rgb_led0_b}, e.grant, |e.grant, e.pins);
                end
                rst_n = 1'b1;
                push_exp("mid_restart", 1,   4'b0001, 1'b1, 3'b111);
                push_exp("mid_dark",    256, 4'b0001, 1'b1, 3'b111);
                push_exp("mid_relit",   257, 4'b0001, 1'b1, 3'b001);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        color = {C3, C2, C1, C0};
        test_reset();
        test_pwm_duty();
`ifndef RGB_LED_ARB_RR_EN
        test_preempt();
        test_drop_wins();
`else
        test_round_robin();
`endif
        test_release();
        test_pulse();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
